vram_line_fetcher: RTL and testbench



---
 rtl/vram_pkg.sv | 6 +
 rtl/sync_fifo_w32.sv | 45 ++++
 rtl/vram_line_fetcher.sv | 82 ++++++++
 tb/tb_vram_line_fetcher.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared VRAM port widths and line-fetcher state encoding
package vram_pkg;
  localparam int VRAM_WADDR_W = 15;
  localparam int VRAM_DATA_W = 32;
  typedef enum logic {IDLE, FETCH} fetch_state_e;
endpackage

// File: rtl/sync_fifo_w32.sv
// sync_fifo_w32: DEPTH x 32-bit FIFO with registered head word
// Ports: clk, rst_n (async active-low), flush, push/wdata, pop/rdata, full, empty, count
module sync_fifo_w32 #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  // a pop frees the slot this same edge, so push into a full FIFO is fine then
  assign do_push = push && (!full || do_pop);
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= wdata;
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/vram_line_fetcher.sv
// vram_line_fetcher: fetches a run of consecutive VRAM words per line into a FIFO
// Ports: line_start/start_addr/word_count start a run; vram_addr/vram_strobe/vram_rddata/vram_ack
// talk to the arbiter; rd_en/rd_data/rd_valid is the consumer side; busy marks an active run.
// Option VRAM_FETCH_UNDERRUN_EN adds a sticky underrun output (pop of an empty FIFO).
module vram_line_fetcher
  import vram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    line_start,
  input  logic [VRAM_WADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]        word_count,
  output logic [VRAM_WADDR_W-1:0] vram_addr,
  output logic                    vram_strobe,
  input  logic [VRAM_DATA_W-1:0]  vram_rddata,
  input  logic                    vram_ack,
  input  logic                    rd_en,
  output logic [VRAM_DATA_W-1:0]  rd_data,
  output logic                    rd_valid,
`ifdef VRAM_FETCH_UNDERRUN_EN
  output logic                    underrun,
`endif
  output logic                    busy
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_e state_q, state_d;
  logic [VRAM_WADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic inflight_q, inflight_d;
  logic fetch, restart, ack_ok, push, full, empty;
  logic [CW-1:0] count;
  assign fetch = state_q == FETCH;
  assign restart = line_start && fetch;
  // the ack right after a restart answers the old run's last grant
  assign ack_ok = vram_ack && fetch && !inflight_q;
  assign push = ack_ok && !line_start;
  assign vram_addr = addr_q + VRAM_WADDR_W'(ack_ok);
  // the acked word lands this edge, so it already counts against words left and FIFO room
  assign vram_strobe = fetch && rem_q > CNT_W'(ack_ok) && !full && (!ack_ok || count != CW'(DEPTH - 1));
  assign busy = fetch;
  assign rd_valid = !empty;
  always_comb begin
    state_d = line_start ? (word_count != '0 ? FETCH : IDLE) : (ack_ok && rem_q == CNT_W'(1)) ? IDLE : state_q;
    addr_d = line_start ? start_addr : vram_addr;
    rem_d = line_start ? word_count : rem_q - CNT_W'(ack_ok && rem_q != '0);
    inflight_d = restart;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      inflight_q <= inflight_d;
    end
  sync_fifo_w32 #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (restart),
    .push  (push),
    .pop   (rd_en),
    .wdata (vram_rddata),
    .rdata (rd_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );
`ifdef VRAM_FETCH_UNDERRUN_EN
  logic underrun_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) underrun_q <= 1'b0;
    else underrun_q <= line_start ? 1'b0 : underrun_q | (rd_en & ~rd_valid);
  assign underrun = underrun_q;
`endif
endmodule

// File: tb/tb_vram_line_fetcher.sv
// tb_vram_line_fetcher: directed self-checking bench with a simple arbiter model
module tb_vram_line_fetcher;
  logic clk = 1'b0, rst_n = 1'b0, line_start = 1'b0, rd_en = 1'b0, gnt_en = 1'b1;
  logic vram_ack, vram_strobe, rd_valid, busy;
  logic [14:0] start_addr = '0, vram_addr;
  logic [7:0] word_count = '0;
  logic [31:0] vram_rddata, rd_data;
  logic [14:0] gnt_log[$];
  int n_chk = 0, n_pass = 0;
`ifdef VRAM_FETCH_UNDERRUN_EN
  logic underrun;
`endif
  always #5 clk = ~clk;
  vram_line_fetcher #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .start_addr(start_addr),
    .word_count(word_count), .vram_addr(vram_addr), .vram_strobe(vram_strobe),
    .vram_rddata(vram_rddata), .vram_ack(vram_ack), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid),
`ifdef VRAM_FETCH_UNDERRUN_EN
    .underrun(underrun),
`endif
    .busy(busy)
  );
  function automatic logic [31:0] pat(input logic [14:0] a);
    return {8'hA5, 9'h000, a};
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vram_ack <= 1'b0;
      vram_rddata <= '0;
    end else begin
      vram_ack <= vram_strobe && gnt_en;
      vram_rddata <= (vram_strobe && gnt_en) ? pat(vram_addr) : 32'h0;
      if (vram_strobe && gnt_en) gnt_log.push_back(vram_addr);
    end
  task automatic start_line(input logic [14:0] a, input logic [7:0] n);
    @(negedge clk);
    line_start = 1'b1;
    start_addr = a;
    word_count = n;
    @(negedge clk);
    line_start = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++; if (vram_addr !== 15'h0) $display("FAIL reset_addr got %h exp 0000", vram_addr); else n_pass++;
    n_chk++; if (vram_strobe !== 1'b0) $display("FAIL reset_strobe got %b exp 0", vram_strobe); else n_pass++;
    n_chk++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data got %h exp 00000000", rd_data); else n_pass++;
    n_chk++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b exp 0", rd_valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
`ifdef VRAM_FETCH_UNDERRUN_EN
    n_chk++; if (underrun !== 1'b0) $display("FAIL reset_underrun got %b exp 0", underrun); else n_pass++;
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_uncontended();
    logic [14:0] a;
    gnt_en = 1'b1;
    start_line(15'h0100, 8'd4);
    n_chk++; if (busy !== 1'b1) $display("FAIL unc_busy_start got %b exp 1", busy); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      a = 15'h0100 + 15'(k);
      n_chk++; if (vram_strobe !== 1'b1 || vram_addr !== a) $display("FAIL unc_req%0d got strobe=%b addr=%h exp strobe=1 addr=%h", k, vram_strobe, vram_addr, a); else n_pass++;
      @(negedge clk);
    end
    n_chk++; if (vram_strobe !== 1'b0 || busy !== 1'b1) $display("FAIL unc_last_ack got strobe=%b busy=%b exp strobe=0 busy=1", vram_strobe, busy); else n_pass++;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || rd_valid !== 1'b1) $display("FAIL unc_done got busy=%b rd_valid=%b exp busy=0 rd_valid=1", busy, rd_valid); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      a = 15'h0100 + 15'(k);
      n_chk++; if (rd_valid !== 1'b1 || rd_data !== pat(a)) $display("FAIL unc_pop%0d got valid=%b data=%h exp valid=1 data=%h", k, rd_valid, rd_data, pat(a)); else n_pass++;
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    n_chk++; if (rd_valid !== 1'b0) $display("FAIL unc_drained got %b exp 0", rd_valid); else n_pass++;
  endtask
  task automatic test_contended();
    logic [14:0] a;
    gnt_log.delete();
    gnt_en = 1'b0;
    start_line(15'h0200, 8'd3);
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (vram_strobe !== 1'b1 || vram_addr !== 15'h0200) $display("FAIL cont_hold%0d got strobe=%b addr=%h exp strobe=1 addr=0200", k, vram_strobe, vram_addr); else n_pass++;
      @(negedge clk);
    end
    gnt_en = 1'b1;
    for (int k = 0; k < 50 && busy; k++) @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL cont_idle got busy=%b exp 0", busy); else n_pass++;
    n_chk++; if (gnt_log.size() != 3) $display("FAIL cont_grants got %0d exp 3", gnt_log.size()); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      a = 15'h0200 + 15'(k);
      n_chk++; if (rd_valid !== 1'b1 || rd_data !== pat(a)) $display("FAIL cont_pop%0d got valid=%b data=%h exp valid=1 data=%h", k, rd_valid, rd_data, pat(a)); else n_pass++;
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    n_chk++; if (rd_valid !== 1'b0) $display("FAIL cont_drained got %b exp 0", rd_valid); else n_pass++;
  endtask
  task automatic test_backpressure();
    int occ = 0, max_occ = 0, popped = 0;
    logic [14:0] a;
    gnt_en = 1'b1;
    start_line(15'h0300, 8'd10);
    for (int c = 0; c < 300 && popped < 10; c++) begin
      rd_en = (c % 3 == 0) && rd_valid;
      if (rd_en) begin
        a = 15'h0300 + 15'(popped);
        n_chk++; if (rd_data !== pat(a)) $display("FAIL bp_pop%0d got %h exp %h", popped, rd_data, pat(a)); else n_pass++;
        popped++;
      end
      occ = occ + int'(vram_ack) - int'(rd_en);
      if (occ > max_occ) max_occ = occ;
      @(negedge clk);
    end
    rd_en = 1'b0;
    n_chk++; if (popped != 10) $display("FAIL bp_count got %0d exp 10", popped); else n_pass++;
    n_chk++; if (max_occ > 4) $display("FAIL bp_max_occ got %0d exp <=4", max_occ); else n_pass++;
    n_chk++; if (busy !== 1'b0 || rd_valid !== 1'b0) $display("FAIL bp_end got busy=%b valid=%b exp 0 0", busy, rd_valid); else n_pass++;
  endtask
  task automatic test_wrap();
    logic [14:0] a, g;
    gnt_log.delete();
    gnt_en = 1'b1;
    start_line(15'h7FFE, 8'd4);
    for (int k = 0; k < 50 && busy; k++) @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL wrap_idle got busy=%b exp 0", busy); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      a = 15'h7FFE + 15'(k);
      g = (k < gnt_log.size()) ? gnt_log[k] : 15'hxxxx;
      n_chk++; if (g !== a) $display("FAIL wrap_addr%0d got %h exp %h", k, g, a); else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      a = 15'h7FFE + 15'(k);
      n_chk++; if (rd_valid !== 1'b1 || rd_data !== pat(a)) $display("FAIL wrap_pop%0d got valid=%b data=%h exp valid=1 data=%h", k, rd_valid, rd_data, pat(a)); else n_pass++;
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
  endtask
  task automatic test_restart();
    logic [14:0] a;
    gnt_en = 1'b1;
    start_line(15'h1000, 8'd8);
    repeat (2) @(negedge clk);
    n_chk++; if (vram_strobe !== 1'b1) $display("FAIL rst_pre_strobe got %b exp 1", vram_strobe); else n_pass++;
    line_start = 1'b1;
    start_addr = 15'h2000;
    word_count = 8'd2;
    @(negedge clk);
    line_start = 1'b0;
    n_chk++; if (rd_valid !== 1'b0) $display("FAIL rst_flushed got valid=%b exp 0", rd_valid); else n_pass++;
    n_chk++; if (vram_addr !== 15'h2000 || busy !== 1'b1) $display("FAIL rst_reload got addr=%h busy=%b exp addr=2000 busy=1", vram_addr, busy); else n_pass++;
    for (int k = 0; k < 50 && busy; k++) @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_idle got busy=%b exp 0", busy); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      a = 15'h2000 + 15'(k);
      n_chk++; if (rd_valid !== 1'b1 || rd_data !== pat(a)) $display("FAIL rst_pop%0d got valid=%b data=%h exp valid=1 data=%h", k, rd_valid, rd_data, pat(a)); else n_pass++;
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    n_chk++; if (rd_valid !== 1'b0) $display("FAIL rst_drained got %b exp 0", rd_valid); else n_pass++;
  endtask
  task automatic test_zero_count();
    start_line(15'h0400, 8'd0);
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (vram_strobe !== 1'b0 || busy !== 1'b0) $display("FAIL zero_idle%0d got strobe=%b busy=%b exp 0 0", k, vram_strobe, busy); else n_pass++;
      @(negedge clk);
    end
`ifdef VRAM_FETCH_UNDERRUN_EN
    n_chk++; if (underrun !== 1'b0) $display("FAIL zero_underrun_pre got %b exp 0", underrun); else n_pass++;
`endif
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    n_chk++; if (rd_valid !== 1'b0) $display("FAIL zero_empty_pop got valid=%b exp 0", rd_valid); else n_pass++;
`ifdef VRAM_FETCH_UNDERRUN_EN
    n_chk++; if (underrun !== 1'b1) $display("FAIL zero_underrun_set got %b exp 1", underrun); else n_pass++;
    start_line(15'h0400, 8'd0);
    n_chk++; if (underrun !== 1'b0) $display("FAIL zero_underrun_clr got %b exp 0", underrun); else n_pass++;
`endif
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_uncontended();
    test_contended();
    test_backpressure();
    test_wrap();
    test_restart();
    test_zero_count();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
